// File: rtl/avl_mm_pkg.sv
// Shared definitions for the Avalon-MM mini agent memory: request FSM states
// and the parameter limits the agent supports.
package avl_mm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCEPT = 2'd2
  } state_t;

  localparam int MAX_READ_LATENCY = 8;
  localparam int MAX_WAIT_CYCLES  = 15;
  localparam int CNT_W            = $clog2(MAX_WAIT_CYCLES + 1);

endpackage

// File: rtl/avl_mm_rdpipe.sv
// Read-response pipeline: valid/data shift register of depth DEPTH with a
// synchronous clear. Data is zeroed on entry when invalid, so o_data is 0
// whenever o_valid is low.
module avl_mm_rdpipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DEPTH-1:0]      r_valid;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/avl_mm_mini_agent_mem.sv
// Avalon-MM mini agent backed by a register-array memory, with a configurable
// number of waitrequest cycles per transfer and a fixed, pipelined read latency.
module avl_mm_mini_agent_mem
  import avl_mm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic                  waitrequest,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LAT   = (READ_LATENCY < 1) ? 1 :
                         (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
  localparam int WC    = (WAIT_CYCLES < 0) ? 0 :
                         (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;
  localparam bit ZERO_WAIT = (WC == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = ZERO_WAIT ? '0 : CNT_W'(WC - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_req;
  logic                  w_accept;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_pipe_valid;
  logic [DATA_WIDTH-1:0] w_pipe_data;

  assign w_req    = read | write;
  assign w_accept = ~reset & w_req &
                    (ZERO_WAIT ? (r_state == IDLE) : (r_state == ACCEPT));
  // Write wins a simultaneous read/write; the read is silently dropped.
  assign w_wr_acc = w_accept & write;
  assign w_rd_acc = w_accept & read & ~write;

  // The IDLE cycle that first sees the request already stalls the host, so
  // WAIT only has to cover the remaining WC-1 stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!ZERO_WAIT && w_req) begin
            r_cnt   <= CNT_LOAD;
            r_state <= (CNT_LOAD == '0) ? ACCEPT : WAIT;
          end
        end
        WAIT: begin
          if (!w_req) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ACCEPT;
            end
          end
        end
        ACCEPT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign waitrequest = reset | (r_state == WAIT) | ((r_state == IDLE) & ~ZERO_WAIT);

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[address] <= writedata;
    end
  end

  avl_mm_rdpipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (LAT)
  ) u_rdpipe (
    .clk     (clk),
    .i_clear (reset),
    .i_valid (w_rd_acc),
    .i_data  (r_mem[address]),
    .o_valid (w_pipe_valid),
    .o_data  (w_pipe_data)
  );

  assign readdatavalid = w_pipe_valid & ~reset;
  assign readdata      = readdatavalid ? w_pipe_data : '0;

endmodule

// File: tb/tb_avl_mm_mini_agent_mem.sv
// Bench for avl_mm_mini_agent_mem: three agents with different wait/latency
// settings, a host driver task, and a per-agent expected-response queue.
module tb_avl_mm_mini_agent_mem;

  localparam int ND    = 3;
  localparam int WC[ND] = '{1, 0, 3};
  localparam int RL[ND] = '{2, 3, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        rd   [ND];
  logic        wr   [ND];
  logic [7:0]  ad   [ND];
  logic [31:0] wd   [ND];
  logic        wreq [ND];
  logic        rdv  [ND];
  logic [31:0] rdat [ND];

  logic [31:0] model_mem [ND][256];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] exp_q2[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  avl_mm_mini_agent_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(RL[0]), .WAIT_CYCLES(WC[0])) dut0 (
    .clk(clk), .reset(reset), .read(rd[0]), .write(wr[0]), .address(ad[0]), .writedata(wd[0]),
    .waitrequest(wreq[0]), .readdata(rdat[0]), .readdatavalid(rdv[0]));
  avl_mm_mini_agent_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(RL[1]), .WAIT_CYCLES(WC[1])) dut1 (
    .clk(clk), .reset(reset), .read(rd[1]), .write(wr[1]), .address(ad[1]), .writedata(wd[1]),
    .waitrequest(wreq[1]), .readdata(rdat[1]), .readdatavalid(rdv[1]));
  avl_mm_mini_agent_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(RL[2]), .WAIT_CYCLES(WC[2])) dut2 (
    .clk(clk), .reset(reset), .read(rd[2]), .write(wr[2]), .address(ad[2]), .writedata(wd[2]),
    .waitrequest(wreq[2]), .readdata(rdat[2]), .readdatavalid(rdv[2]));

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_exp(int d, logic [63:0] e);
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop_exp(int d, output logic [63:0] e);
    bit ok;
    ok = 1'b0;
    e  = '0;
    case (d)
      0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
      1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); ok = 1'b1; end
    endcase
    return ok;
  endfunction

  function automatic int q_size(int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  // Monitor: every readdatavalid pops the oldest expected response
  // (data in [31:0], due cycle in [63:32]).
  function automatic void mon_step(int d);
    logic [63:0] e;
    if (rdv[d] === 1'b1) begin
      if (!pop_exp(d, e)) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdv[%0d]: got readdata 0x%0h with no read pending (cycle %0d)", d, rdat[d], cyc);
      end else begin
        check($sformatf("rd_data[%0d]", d), 64'(rdat[d]), 64'(e[31:0]));
        check($sformatf("rd_cycle[%0d]", d), 64'(cyc), 64'(e[63:32]));
      end
    end else begin
      check($sformatf("rdv_low_data[%0d]", d), 64'(rdat[d]), 64'(0));
    end
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < ND; d++) mon_step(d);
    end
  end

  // Host transfer: called at posedge+1, returns at posedge+1 after acceptance.
  task automatic xfer(int d, bit r, bit w, logic [7:0] a, logic [31:0] data);
    int waits;
    rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = data;
    waits = 0;
    @(negedge clk);
    while (wreq[d] && waits < 64) begin
      waits++;
      @(negedge clk);
    end
    if (wreq[d]) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout[%0d]: waitrequest=1 after %0d cycles, required 0", d, waits);
    end else begin
      check($sformatf("wait_cycles[%0d]", d), 64'(waits), 64'(WC[d]));
      if (w) model_mem[d][a] = data;
      else if (r) push_exp(d, {32'(cyc + RL[d]), model_mem[d][a]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int d, int n);
    rd[d] = 1'b0; wr[d] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; wd[d] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset_waitreq[%0d]", d), 64'(wreq[d]), 64'(1));
      check($sformatf("reset_rdv[%0d]", d), 64'(rdv[d]), 64'(0));
      check($sformatf("reset_rdata[%0d]", d), 64'(rdat[d]), 64'(0));
    end
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      check($sformatf("idle_waitreq[%0d]", d), 64'(wreq[d]), 64'(WC[d] > 0));
    @(posedge clk); #1;

    for (int d = 0; d < ND; d++) begin
      for (int a = 0; a < 64; a++) xfer(d, 1'b0, 1'b1, 8'(a), $urandom);
      idle(d, 1);
    end

    // Single-wait write then read-back with latency 2; host sees the stall again in IDLE.
    xfer(0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    rd[0] = 1'b0; wr[0] = 1'b0;
    @(negedge clk);
    check("post_accept_idle_waitreq", 64'(wreq[0]), 64'(1));
    @(posedge clk); #1;
    xfer(0, 1'b1, 1'b0, 8'h10, '0);
    idle(0, 4);

    // Simultaneous read/write: write lands, read produces nothing.
    xfer(0, 1'b1, 1'b1, 8'h20, 32'h5);
    xfer(0, 1'b1, 1'b0, 8'h20, '0);
    idle(0, 4);

    // Zero-wait, latency 3: four back-to-back reads of preloaded words.
    for (int i = 0; i < 4; i++) xfer(1, 1'b0, 1'b1, 8'(i), 32'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) xfer(1, 1'b1, 1'b0, 8'(i), '0);
    idle(1, 6);

    // Read abandoned after one stall cycle: no response, next read stalls the full count.
    rd[2] = 1'b1; wr[2] = 1'b0; ad[2] = 8'h05;
    @(negedge clk);
    check("abort_waitreq", 64'(wreq[2]), 64'(1));
    @(posedge clk); #1;
    idle(2, 5);
    xfer(2, 1'b1, 1'b0, 8'h05, '0);
    idle(2, 3);

    // Reset with two reads in flight discards both; memory survives reset.
    xfer(1, 1'b0, 1'b1, 8'h30, 32'hCAFE0001);
    xfer(1, 1'b1, 1'b0, 8'h30, '0);
    xfer(1, 1'b1, 1'b0, 8'h31, '0);
    rd[1] = 1'b0; wr[1] = 1'b0;
    reset = 1'b1;
    exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1, 6);
    xfer(1, 1'b1, 1'b0, 8'h30, '0);
    idle(1, 5);

    // Randomized mix: reads, writes, read+write collisions and idle gaps.
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 80; n++) begin
        int op;
        logic [7:0] a;
        op = $urandom_range(0, 4);
        a  = 8'($urandom_range(0, 63));
        case (op)
          0, 1:    xfer(d, 1'b1, 1'b0, a, '0);
          2:       xfer(d, 1'b0, 1'b1, a, $urandom);
          3:       xfer(d, 1'b1, 1'b1, a, $urandom);
          default: idle(d, $urandom_range(1, 3));
        endcase
      end
      idle(d, 12);
    end

    for (int d = 0; d < ND; d++)
      check($sformatf("drained[%0d]", d), 64'(q_size(d)), 64'(0));

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avl_mm_mini_agent_mem.md
AVL_MM_MINI_AGENT_MEM -- requirements
Module: avl_mm_mini_agent_mem

Interface
REQ-001 Parameter DATA_WIDTH SHALL be: default 32; data width in bits.
REQ-002 Parameter ADDR_WIDTH SHALL be: default 8; word address width, so memory depth is 2**ADDR_WIDTH.
REQ-003 Parameter READ_LATENCY SHALL be: default 2; cycles from read acceptance to readdatavalid; legal range 1..8.
REQ-004 Parameter WAIT_CYCLES SHALL be: default 1; waitrequest cycles inserted before each transfer is accepted; legal range 0..15.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk SHALL be: input, 1 bit, sole clock, rising edge.
REQ-007 Port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-008 Port read SHALL be: input, 1 bit, host read request.
REQ-009 Port write SHALL be: input, 1 bit, host write request.
REQ-010 Port address SHALL be: input, ADDR_WIDTH bits, word address.
REQ-011 Port writedata SHALL be: input, DATA_WIDTH bits, write data.
REQ-012 Port waitrequest SHALL be: output, 1 bit, agent stall.
REQ-013 Port readdata SHALL be: output, DATA_WIDTH bits, read response data.
REQ-014 Port readdatavalid SHALL be: output, 1 bit, readdata qualifier.

Function
REQ-015 The block SHALL act as the agent end of the Avalon-MM mini interface, backed by a 2**ADDR_WIDTH x DATA_WIDTH register array.
REQ-016 The request FSM SHALL have three states: IDLE, WAIT and ACCEPT, defined as follows.
REQ-017 In IDLE with read or write asserted and WAIT_CYCLES>0: waitrequest=1, load the counter with WAIT_CYCLES-1, and go to WAIT.
REQ-018 In IDLE with WAIT_CYCLES=0: waitrequest=0, and any request is accepted in the same cycle (zero-wait, back-to-back capable).
REQ-019 In WAIT: waitrequest=1 and the counter decrements; at counter=0 the FSM goes to ACCEPT.
REQ-020 In ACCEPT: waitrequest=0, the transfer is accepted on that edge, and the FSM returns to IDLE.
REQ-021 In IDLE with no request: waitrequest SHALL be 0 when WAIT_CYCLES=0 and 1 when WAIT_CYCLES>0.
REQ-022 If read and write both deassert during WAIT, the FSM SHALL return to IDLE with no transfer performed.
REQ-023 On an accepted write, mem[address] SHALL be updated with writedata on that edge.
REQ-024 If read and write are asserted together, write SHALL take priority and the read SHALL be dropped (no readdatavalid).
REQ-025 An accepted read at edge T SHALL capture mem[address] (pre-write value) and assert readdatavalid for exactly one cycle, READ_LATENCY cycles after T.
REQ-026 Reads SHALL be fully pipelined: up to READ_LATENCY reads in flight, with responses in acceptance order and no gaps inserted.
REQ-027 A write accepted at T followed by a read of the same address accepted at T+1 or later SHALL return the new data.
REQ-028 readdata SHALL be 0 whenever readdatavalid=0.
REQ-029 Writes SHALL NOT disturb in-flight read responses.

Reset
REQ-030 On reset the block SHALL enter IDLE with counter=0, clear the read pipeline (in-flight reads discarded), drive readdatavalid=0 and readdata=0, and drive waitrequest=1 while reset is asserted.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset asserted mid-WAIT or with reads in flight SHALL suppress all pending responses from the next cycle on.

Structure
REQ-033 Package avl_mm_pkg SHALL hold the FSM state enum (IDLE, WAIT, ACCEPT) and the max-latency/max-wait constants.
REQ-034 The read-latency pipeline SHALL be the sub-module avl_mm_rdpipe: a valid/data shift register of depth READ_LATENCY with synchronous clear.
REQ-035 Ports SHALL map one-to-one onto the agnt modport signals of avl_mm_mini_if so the block binds directly to that modport.

Verification
REQ-036 With WAIT_CYCLES=1, write 0xDEADBEEF to address 0x10: waitrequest=1 for 1 cycle, then 0 for 1 cycle; a read of 0x10 then returns 0xDEADBEEF with readdatavalid 2 cycles after acceptance.
REQ-037 With WAIT_CYCLES=0 and READ_LATENCY=3, 4 back-to-back reads of 0x00..0x03 preloaded 0x11..0x44: waitrequest stays 0, and readdatavalid is high for 4 consecutive cycles starting 3 cycles after the first read, in order.
REQ-038 With read and write both high at 0x20 and writedata=0x5: mem[0x20]=0x5 and no readdatavalid is produced.
REQ-039 With WAIT_CYCLES=3, read deasserted after 1 wait cycle: no transfer, FSM in IDLE, no readdatavalid.
REQ-040 With 2 reads in flight, reset pulsed for 1 cycle: readdatavalid stays 0 thereafter, and a read of a previously written address after reset returns the pre-reset data.
